// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered command issue stage for the 8-bit ALU; returns the sampled Y on a
// valid/ready result port. Define ALU_ISSUE_FLAGS_EN to register zero/negative result flags.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_a,
    input  logic [7:0]                 cmd_b,
    input  logic [3:0]                 cmd_op,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic [3:0]                 alu_op,
    output logic                       alu_trigger,
    input  logic [7:0]                 alu_y,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_data,
    output logic                       res_err,
    output logic                       res_zero,
    output logic                       res_neg
);
    // state     | meaning
    // S_IDLE    | no command in flight; pops as soon as the FIFO is non-empty
    // S_SETUP   | operands stable on alu_a/b/op; illegal op diverts straight to S_RESP
    // S_FIRE    | alu_trigger high for this single cycle
    // S_CAPTURE | trigger low; Y sampled into res_data on exit
    // S_RESP    | res_valid high, result held until res_ready

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FIRE,
        S_CAPTURE,
        S_RESP
    } state_t;

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    cmd_t          head;

    function automatic logic op_illegal(input logic [3:0] op);
        return op[3:1] == 3'b111;
    endfunction

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != FULL_COUNT);
    assign cmd_count  = count;
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];

    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end else if (state == S_RESP && res_ready) begin
                pop = 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_trigger <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
        end else begin
            alu_trigger <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        alu_op <= head.op;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (op_illegal(alu_op)) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        alu_trigger <= 1'b1;
                        state       <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data  <= alu_y;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        if (pop) begin
                            alu_a  <= head.a;
                            alu_b  <= head.b;
                            alu_op <= head.op;
                            // An illegal follower is answered without leaving RESP.
                            if (op_illegal(head.op)) begin
                                res_data <= '0;
                                res_err  <= 1'b1;
                            end else begin
                                res_valid <= 1'b0;
                                state     <= S_SETUP;
                            end
                        end else begin
                            res_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic load_err;

    assign load_err = (state == S_SETUP && op_illegal(alu_op)) ||
                      (state == S_RESP && res_ready && pop && op_illegal(head.op));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_zero <= 1'b0;
            res_neg  <= 1'b0;
        end else if (state == S_CAPTURE) begin
            res_zero <= (alu_y == 8'h00);
            res_neg  <= alu_y[7];
        end else if (load_err) begin
            res_zero <= 1'b0;
            res_neg  <= 1'b0;
        end
    end
`else
    assign res_zero = 1'b0;
    assign res_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a queue-based
// result model and a trigger-latched ALU model.
module tb_alu_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       zero;
        logic       neg;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_a = '0;
    logic [7:0]    cmd_b = '0;
    logic [3:0]    cmd_op = '0;
    logic [CW-1:0] cmd_count;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_op;
    logic          alu_trigger;
    logic [7:0]    alu_y = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [7:0]    res_data;
    logic          res_err;
    logic          res_zero;
    logic          res_neg;

    int   compared = 0;
    int   mismatched = 0;
    res_t q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_trigger(alu_trigger), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .res_zero(res_zero), .res_neg(res_neg)
    );

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            default: return a + b + {4'h0, op};
        endcase
    endfunction

    // Stand-in ALU: latches Y on the rising edge of trigger.
    always @(posedge alu_trigger) alu_y <= ref_alu(alu_a, alu_b, alu_op);

    function automatic res_t expect_of(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        res_t r;
        if (op == 4'd14 || op == 4'd15) begin
            r = '{data: 8'h00, err: 1'b1, zero: 1'b0, neg: 1'b0};
        end else begin
            r.data = ref_alu(a, b, op);
            r.err  = 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            r.zero = (r.data == 8'h00);
            r.neg  = r.data[7];
`else
            r.zero = 1'b0;
            r.neg  = 1'b0;
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t exp);
        check({tag, "_data"}, res_data, exp.data);
        check({tag, "_err"}, res_err, exp.err);
        check({tag, "_zero"}, res_zero, exp.zero);
        check({tag, "_neg"}, res_neg, exp.neg);
    endtask

    // Entered and left at a falling edge; returns at the falling edge after the accept edge.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, res_valid, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   accepted;
        int   last;
        int   n;
        int   cyc;
        int   last_trig;
        logic held;
        res_t prev;
        res_t e;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_count", cmd_count, 0);
        check("rst_trigger", alu_trigger, 1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_alu", {alu_a, alu_b, alu_op}, 20'h0);
        check_res("rst_res", '{data: 8'h00, err: 1'b0, zero: 1'b0, neg: 1'b0});
        rst = 1'b0;
        @(negedge clk);

        // Single add: trigger over E2-E3, result at E4
        res_ready = 1'b1;
        push_cmd(8'h05, 8'h03, 4'd0);
        check("t1_count_after_accept", cmd_count, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("t1_trig_e%0d", k), alu_trigger, (k == 2));
            check($sformatf("t1_valid_e%0d", k), res_valid, (k == 4));
        end
        check_res("t1_res", expect_of(8'h05, 8'h03, 4'd0));
        check("t1_data_literal", res_data, 8'h08);
        @(negedge clk);
        check("t1_valid_after_hs", res_valid, 1'b0);

        // Illegal opcode: no trigger, result at E2
        push_cmd(8'h12, 8'h34, 4'he);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("ill_trig_e%0d", k), alu_trigger, 1'b0);
            check($sformatf("ill_valid_e%0d", k), res_valid, (k == 2));
        end
        check_res("ill_res", '{data: 8'h00, err: 1'b1, zero: 1'b0, neg: 1'b0});
        @(negedge clk);
        check("ill_valid_after_hs", res_valid, 1'b0);

        // Flag cases: zero result and negative result
        push_cmd(8'h05, 8'h05, 4'd1);
        wait_valid("flag0_valid");
        check_res("flag0_res", expect_of(8'h05, 8'h05, 4'd1));
        @(negedge clk);
        push_cmd(8'h03, 8'h05, 4'd1);
        wait_valid("flag1_valid");
        check_res("flag1_res", expect_of(8'h03, 8'h05, 4'd1));
        check("flag1_data_literal", res_data, 8'hfe);
        repeat (2) @(negedge clk);

        // Back-pressure: fill with res_ready low, then drain at one result per 4 cycles
        res_ready = 1'b0;
        accepted = 0;
        cmd_valid = 1'b1;
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_op = 4'($urandom_range(0, 13));
        repeat (12) begin
            if (cmd_ready) begin
                q.push_back(expect_of(cmd_a, cmd_b, cmd_op));
                accepted++;
                @(negedge clk);
                cmd_a = 8'($urandom);
                cmd_b = 8'($urandom);
                cmd_op = 4'($urandom_range(0, 13));
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        check("bp_accepted", accepted, DEPTH + 1);
        check("bp_count_full", cmd_count, DEPTH);
        check("bp_ready_low", cmd_ready, 1'b0);
        check("bp_valid_held", res_valid, 1'b1);
        res_ready = 1'b1;
        last = -1;
        for (n = 0; n < 80 && q.size() > 0; n++) begin
            if (res_valid) begin
                check_res("bp_res", q.pop_front());
                if (last >= 0) check("bp_spacing", n - last, 4);
                last = n;
            end
            @(negedge clk);
        end
        check("bp_drained", q.size(), 0);
        repeat (2) @(negedge clk);

        // Reset while the trigger is high, then a normal command
        push_cmd(8'h21, 8'h11, 4'd2);
        push_cmd(8'h40, 8'h02, 4'd0);
        n = 0;
        while (!alu_trigger && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rr_trig_seen", alu_trigger, 1'b1);
        check("rr_count_before", cmd_count, 1);
        #2 rst = 1'b1;
        #1;
        check("rr_trig_dropped", alu_trigger, 1'b0);
        check("rr_valid_low", res_valid, 1'b0);
        check("rr_count_zero", cmd_count, 0);
        check("rr_ready_high", cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_cmd(8'h9a, 8'h0f, 4'd4);
        wait_valid("rr_post_valid");
        check_res("rr_post_res", expect_of(8'h9a, 8'h0f, 4'd4));
        @(negedge clk);
        check("rr_post_count", cmd_count, 0);

        // Randomized traffic against the result queue
        held = 1'b0;
        prev = '0;
        last_trig = -100;
        for (cyc = 0; cyc < 500; cyc++) begin
            if (held) begin
                check("rnd_hold_valid", res_valid, 1'b1);
                check("rnd_hold_bits", {res_data, res_err, res_zero, res_neg}, prev);
            end
            if (alu_trigger) begin
                check("rnd_trig_gap", (cyc - last_trig) >= 4, 1'b1);
                last_trig = cyc;
            end
            check("rnd_ready_vs_count", cmd_ready, (cmd_count != DEPTH));
            cmd_valid = ($urandom_range(0, 99) < 60);
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            cmd_op = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 99) < 50);
            if (cmd_valid && cmd_ready) q.push_back(expect_of(cmd_a, cmd_b, cmd_op));
            if (res_valid && res_ready) begin
                check("rnd_res_pending", q.size() > 0, 1'b1);
                if (q.size() > 0) check_res("rnd_res", q.pop_front());
            end
            held = res_valid && !res_ready;
            prev = '{data: res_data, err: res_err, zero: res_zero, neg: res_neg};
            @(negedge clk);
        end

        // Drain whatever is still queued
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (n = 0; n < 200 && q.size() > 0; n++) begin
            if (res_valid) begin
                e = q.pop_front();
                check_res("drain_res", e);
            end
            @(negedge clk);
        end
        check("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
        check("drain_valid_low", res_valid, 1'b0);
        check("drain_count", cmd_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
